example: RTL and testbench

EXAMPLE -- requirements
Module: example

---
 rtl/example.sv | 56 +++++
 tb/tb_example.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/example.sv
// rtl/example.sv - selectable 3-input boolean function with registered result and rising-edge counter
module example #(
    parameter int FUNC  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_comb,
    output logic             y_rise,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // next y will be 1 while the current y is 0: a rising edge lands on this clock
    logic rise_next;

    // Function select; any unlisted FUNC value falls back to (a & b) | c
    always_comb begin
        y_comb = (a & b) | c;
        case (FUNC)
            1:       y_comb = a ^ b ^ c;
            2:       y_comb = (a & b) | (a & c) | (b & c);
            3:       y_comb = a & b & c;
            default: y_comb = (a & b) | c;
        endcase
    end

    assign rise_next = y_comb & ~y;

    // Registered result and rise pulse; y resets to 0 so the first post-reset 1 counts as a rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y      <= 1'b0;
            y_rise <= 1'b0;
        end else begin
            y      <= y_comb;
            y_rise <= rise_next;
        end
    end

    // Saturating rise counter, updated on the same edge that raises y_rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_cnt <= '0;
        end else if (rise_next && (rise_cnt != CNT_MAX)) begin
            rise_cnt <= rise_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_example.sv
// tb/tb_example.sv - directed-vector bench for example
module tb_example;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;

    logic       y0, yc0, yr0;
    logic [7:0] cnt0;
    logic       y1, yc1, yr1;
    logic [7:0] cnt1;
    logic       y2, yc2, yr2;
    logic [7:0] cnt2;
    logic       y3, yc3, yr3;
    logic [7:0] cnt3;
    logic       y7, yc7, yr7;
    logic [7:0] cnt7;
    logic       ys, ycs, yrs;
    logic [1:0] cnts;

    int vectors = 0;
    int miscompares = 0;

    // truth tables indexed by {a,b,c}
    logic [7:0] tbl_f0 = 8'hEA;
    logic [7:0] tbl_f1 = 8'h96;
    logic [7:0] tbl_f2 = 8'hE8;
    logic [7:0] tbl_f3 = 8'h80;

    always #5 clk = ~clk;

    example #(.FUNC(0), .CNT_W(8)) u_f0 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y0), .y_comb(yc0), .y_rise(yr0), .rise_cnt(cnt0));
    example #(.FUNC(1), .CNT_W(8)) u_f1 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y1), .y_comb(yc1), .y_rise(yr1), .rise_cnt(cnt1));
    example #(.FUNC(2), .CNT_W(8)) u_f2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y2), .y_comb(yc2), .y_rise(yr2), .rise_cnt(cnt2));
    example #(.FUNC(3), .CNT_W(8)) u_f3 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y3), .y_comb(yc3), .y_rise(yr3), .rise_cnt(cnt3));
    example #(.FUNC(7), .CNT_W(8)) u_f7 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y7), .y_comb(yc7), .y_rise(yr7), .rise_cnt(cnt7));
    example #(.FUNC(0), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(ys), .y_comb(ycs), .y_rise(yrs), .rise_cnt(cnts));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // asynchronous reset takes effect without any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_y", 32'(y0), 32'd0);
        check("rst_y_rise", 32'(yr0), 32'd0);
        check("rst_cnt", 32'(cnt0), 32'd0);
        tick();
        rst = 1'b0;

        // full sweep of all functions, including illegal FUNC=7 behaving as FUNC=0
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = i[2:0];
            #1;
            check($sformatf("f0_comb_%0d", i), 32'(yc0), 32'(tbl_f0[i]));
            check($sformatf("f1_comb_%0d", i), 32'(yc1), 32'(tbl_f1[i]));
            check($sformatf("f2_comb_%0d", i), 32'(yc2), 32'(tbl_f2[i]));
            check($sformatf("f3_comb_%0d", i), 32'(yc3), 32'(tbl_f3[i]));
            check($sformatf("f7_comb_%0d", i), 32'(yc7), 32'(tbl_f0[i]));
            tick();
            check($sformatf("f0_y_%0d", i), 32'(y0), 32'(tbl_f0[i]));
            check($sformatf("f1_y_%0d", i), 32'(y1), 32'(tbl_f1[i]));
            check($sformatf("f2_y_%0d", i), 32'(y2), 32'(tbl_f2[i]));
            check($sformatf("f3_y_%0d", i), 32'(y3), 32'(tbl_f3[i]));
        end

        // single rise from reset: 000 then 001
        {a, b, c} = 3'b000;
        pulse_reset();
        tick();
        check("r19_y0", 32'(y0), 32'd0);
        check("r19_rise0", 32'(yr0), 32'd0);
        check("r19_cnt0", 32'(cnt0), 32'd0);
        c = 1'b1;
        tick();
        check("r19_y1", 32'(y0), 32'd1);
        check("r19_rise1", 32'(yr0), 32'd1);
        check("r19_cnt1", 32'(cnt0), 32'd1);
        tick();
        check("r19_hold_rise", 32'(yr0), 32'd0);
        check("r19_hold_cnt", 32'(cnt0), 32'd1);
        c = 1'b0;
        tick();
        check("r19_fall_y", 32'(y0), 32'd0);
        check("r19_fall_rise", 32'(yr0), 32'd0);
        check("r19_fall_cnt", 32'(cnt0), 32'd1);

        // back-to-back toggling with a 2-bit saturating counter
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            c = 1'b1;
            tick();
            check($sformatf("sat_rise_%0d", i), 32'(yrs), 32'd1);
            check($sformatf("sat_cnt_%0d", i), 32'(cnts), (i < 3) ? 32'(i + 1) : 32'd3);
            c = 1'b0;
            tick();
            check($sformatf("sat_fall_%0d", i), 32'(yrs), 32'd0);
        end

        // async reset between edges while y=1 and count=3
        c = 1'b1;
        tick();
        check("mid_y_pre", 32'(ys), 32'd1);
        check("mid_cnt_pre", 32'(cnts), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_y", 32'(ys), 32'd0);
        check("mid_cnt", 32'(cnts), 32'd0);
        check("mid_rise", 32'(yrs), 32'd0);
        check("mid_comb", 32'(ycs), 32'd1);
        tick();
        rst = 1'b0;

        // first edge after reset loads a 1 and counts it as a rise
        tick();
        check("post_y", 32'(ys), 32'd1);
        check("post_rise", 32'(yrs), 32'd1);
        check("post_cnt", 32'(cnts), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
